// File: rtl/t07_arb_pkg.sv
// t07 memory arbiter shared types and constants.
// Imported by the arbiter top and its timeout timer.
package t07_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } arb_grant_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [3:0]  SEL_WORD  = 4'hF;

endpackage

// File: rtl/t07_arb_timer.sv
// Ack-wait counter for the t07 arbiter; only instantiated when
// T07_ARB_TIMEOUT_EN is defined.
module t07_arb_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    // expires on the edge where the count would reach LIMIT
    assign expired_o = en_i & (cnt_q == CW'(LIMIT - 1));

    // clear on grant, count each waiting cycle
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/t07_mem_arbiter.sv
// t07 memory arbiter: one memory port shared by fetch and LSU.
// Define T07_ARB_TIMEOUT_EN to abort accesses whose ack never comes.
module t07_mem_arbiter
    import t07_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_sel,
    output logic [DATA_W-1:0] instr_o,
    output logic              if_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              stall_o,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_sel,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              arb_err
);

    arb_state_e        state_q, state_d;
    arb_grant_e        last_q, last_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        sel_q, sel_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ifd_q, ifd_d;
    logic              dd_q, dd_d;
    logic              err_q, err_d;

    logic f_pend, d_pend, pick_d, pick_f;
    logic busy, grant, tmo;

    // a requester whose done is pulsing is not yet a new request
    assign f_pend = if_req & ~ifd_q;
    assign d_pend = (d_read | d_write) & ~dd_q;
    assign pick_d = d_pend & (~f_pend | (last_q != GNT_DATA));
    assign pick_f = f_pend & ~pick_d;
    assign busy   = (state_q != ST_IDLE);
    assign grant  = ~busy & (pick_d | pick_f);

`ifdef T07_ARB_TIMEOUT_EN
    t07_arb_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .nrst     (nrst),
        .clr_i    (grant),
        .en_i     (busy & ~mem_ack),
        .expired_o(tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    // arbitration, completion and timeout next-state logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        instr_d = instr_q;
        rdata_d = rdata_q;
        ifd_d   = 1'b0;
        dd_d    = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_d) begin
                    state_d = ST_DATA;
                    req_d   = 1'b1;
                    we_d    = d_write;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    sel_d   = d_sel;
                end else if (pick_f) begin
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    sel_d   = SEL_WORD;
                end
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    last_d  = GNT_FETCH;
                    instr_d = mem_rdata;
                    ifd_d   = 1'b1;
                end else if (tmo) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    last_d  = GNT_FETCH;
                    instr_d = DATA_W'(NOP_INSTR);
                    ifd_d   = 1'b1;
                    err_d   = 1'b1;
                end
            end
            ST_DATA: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    last_d  = GNT_DATA;
                    dd_d    = 1'b1;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end else if (tmo) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    last_d  = GNT_DATA;
                    rdata_d = DATA_W'(NOP_INSTR);
                    dd_d    = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            last_q  <= GNT_FETCH;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            instr_q <= '0;
            rdata_q <= '0;
            ifd_q   <= 1'b0;
            dd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
            ifd_q   <= ifd_d;
            dd_q    <= dd_d;
            err_q   <= err_d;
        end
    end

    // freeze while a request is outstanding; quiet during reset
    assign stall_o = nrst & ((if_req & ~ifd_q) |
                             ((d_read | d_write) & ~dd_q));

    assign instr_o   = instr_q;
    assign if_done   = ifd_q;
    assign d_rdata   = rdata_q;
    assign d_done    = dd_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_sel   = sel_q;
    assign arb_err   = err_q;

endmodule

// File: tb/tb_t07_mem_arbiter.sv
// Self-checking bench for t07_mem_arbiter: directed scenarios plus
// random traffic against a transaction-level memory/arbiter model.
module tb_t07_mem_arbiter;

    localparam int TMO = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        nrst;
    logic        if_req, d_read, d_write, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_sel;
    logic [31:0] instr_o, d_rdata, mem_addr, mem_wdata;
    logic        if_done, d_done, stall_o, mem_req, mem_we, arb_err;
    logic [3:0]  mem_sel;

    always #5 clk = ~clk;

    t07_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .nrst(nrst),
        .if_req(if_req), .if_addr(if_addr),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_sel(d_sel),
        .instr_o(instr_o), .if_done(if_done),
        .d_rdata(d_rdata), .d_done(d_done), .stall_o(stall_o),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_sel(mem_sel),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .arb_err(arb_err)
    );

    int total = 0;
    int bad   = 0;

    // model: c_* = expected this cycle, n_* = after coming edge
    bit          c_busy, n_busy, c_win, n_win, c_we, n_we;
    bit          c_fd, n_fd, c_dd, n_dd, c_err, n_err;
    logic [31:0] c_addr, n_addr, c_wdata, n_wdata;
    logic [3:0]  c_sel, n_sel;
    logic [31:0] c_instr, n_instr, c_rdata, n_rdata;
    bit          m_last;
    int          wait_left, cnt;
    int          fixed_wait = -1;
    bit          no_ack = 0, force_ack = 0;
    logic [31:0] mem_m [16];

    task automatic advance();
        logic [31:0] rd;
        bit fr, dr;
        rd = 32'h0;
        n_busy = c_busy; n_win = c_win; n_we = c_we;
        n_addr = c_addr; n_wdata = c_wdata; n_sel = c_sel;
        n_instr = c_instr; n_rdata = c_rdata;
        n_fd = 0; n_dd = 0; n_err = 0;
        mem_ack = force_ack;
        mem_rdata = $urandom;
        if (nrst == 1'b0) begin
            n_busy = 0; n_win = 0; n_we = 0;
            n_addr = '0; n_wdata = '0; n_sel = '0;
            n_instr = '0; n_rdata = '0;
            m_last = 0; cnt = 0;
        end else if (c_busy) begin
            if (force_ack || (!no_ack && wait_left == 0)) begin
                mem_ack = 1'b1;
                if (c_we) begin
                    for (int b = 0; b < 4; b++)
                        if (c_sel[b])
                            mem_m[c_addr[5:2]][8*b +: 8] = c_wdata[8*b +: 8];
                end else begin
                    rd = mem_m[c_addr[5:2]];
                    mem_rdata = rd;
                end
                n_busy = 0;
                m_last = c_win;
                if (c_win) begin
                    n_dd = 1;
                    if (!c_we) n_rdata = rd;
                end else begin
                    n_fd = 1;
                    n_instr = rd;
                end
            end else begin
                if (wait_left > 0) wait_left--;
                cnt++;
`ifdef T07_ARB_TIMEOUT_EN
                if (cnt == TMO) begin
                    n_busy = 0; n_err = 1; m_last = c_win;
                    if (c_win) begin n_dd = 1; n_rdata = NOP; end
                    else begin n_fd = 1; n_instr = NOP; end
                end
`endif
            end
        end else begin
            fr = (if_req === 1'b1) && !c_fd;
            dr = ((d_read === 1'b1) || (d_write === 1'b1)) && !c_dd;
            if (dr && (!fr || m_last == 0)) begin
                n_busy = 1; n_win = 1; n_we = d_write;
                n_addr = d_addr; n_wdata = d_wdata; n_sel = d_sel;
            end else if (fr) begin
                n_busy = 1; n_win = 0; n_we = 0;
                n_addr = if_addr; n_wdata = '0; n_sel = 4'hF;
            end
            if (n_busy) begin
                cnt = 0;
                wait_left = (fixed_wait >= 0) ? fixed_wait
                                              : int'($urandom_range(0, 3));
            end
        end
    endtask

    task automatic observe();
        logic exp_stall;
        @(negedge clk);
        c_busy = n_busy; c_win = n_win; c_we = n_we;
        c_addr = n_addr; c_wdata = n_wdata; c_sel = n_sel;
        c_instr = n_instr; c_rdata = n_rdata;
        c_fd = n_fd; c_dd = n_dd; c_err = n_err;
        exp_stall = nrst & ((if_req & ~c_fd) |
                            ((d_read | d_write) & ~c_dd));
        total++;
        if (mem_req !== c_busy) begin
            bad++;
            $display("FAIL mem_req: got %b want %b", mem_req, c_busy);
        end
        if (c_busy) begin
            total++;
            if (mem_addr !== c_addr || mem_we !== c_we ||
                mem_sel !== c_sel) begin
                bad++;
                $display("FAIL fields: got %h/%b/%h want %h/%b/%h",
                         mem_addr, mem_we, mem_sel, c_addr, c_we, c_sel);
            end
            if (c_we) begin
                total++;
                if (mem_wdata !== c_wdata) begin
                    bad++;
                    $display("FAIL wdata: got %h want %h", mem_wdata, c_wdata);
                end
            end
        end
        total++;
        if (if_done !== c_fd || d_done !== c_dd) begin
            bad++;
            $display("FAIL done: got %b%b want %b%b",
                     if_done, d_done, c_fd, c_dd);
        end
        total++;
        if (instr_o !== c_instr) begin
            bad++;
            $display("FAIL instr: got %h want %h", instr_o, c_instr);
        end
        total++;
        if (d_rdata !== c_rdata) begin
            bad++;
            $display("FAIL rdata: got %h want %h", d_rdata, c_rdata);
        end
        total++;
        if (arb_err !== c_err) begin
            bad++;
            $display("FAIL arb_err: got %b want %b", arb_err, c_err);
        end
        total++;
        if (stall_o !== exp_stall) begin
            bad++;
            $display("FAIL stall: got %b want %b", stall_o, exp_stall);
        end
    endtask

    task automatic cyc();
        advance();
        observe();
    endtask

    task automatic wait_for(input int which, input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            cyc();
            case (which)
                0: ok = (mem_req === 1'b1);
                1: ok = (if_done === 1'b1);
                2: ok = (d_done === 1'b1);
                default: ok = (arb_err === 1'b1);
            endcase
            if (ok) break;
        end
    endtask

    task automatic do_reset();
        nrst = 0; if_req = 0; d_read = 0; d_write = 0;
        force_ack = 0; no_ack = 0;
        cyc();
        cyc();
        nrst = 1;
    endtask

    task automatic test_reset();
        int got;
        nrst = 0; if_req = 1; if_addr = 32'h0000_0100;
        d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0; d_sel = 0;
        repeat (3) cyc();
        total++;
        if ({mem_req, mem_we, mem_sel} !== 6'b0 || mem_addr !== 32'h0 ||
            mem_wdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_mem: got %b%b%h %h %h want zeros",
                     mem_req, mem_we, mem_sel, mem_addr, mem_wdata);
        end
        total++;
        if (instr_o !== 32'h0 || d_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: got %h %h want 0 0", instr_o, d_rdata);
        end
        total++;
        if ({if_done, d_done, stall_o, arb_err} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b%b%b%b want 0000",
                     if_done, d_done, stall_o, arb_err);
        end
        mem_m[0] = 32'h0C80_0183;
        fixed_wait = 1;
        nrst = 1;
        got = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (if_done === 1'b1) begin
                got = k;
                break;
            end
        end
        if_req = 0;
        total++;
        if (got != 3) begin
            bad++;
            $display("FAIL reset_fetch_lat: got %0d want 3", got);
        end
        total++;
        if (instr_o !== 32'h0C80_0183) begin
            bad++;
            $display("FAIL reset_fetch_instr: got %h want 0c800183", instr_o);
        end
        cyc();
    endtask

    task automatic test_contention();
        bit ok;
        logic [31:0] fa, da;
        do_reset();
        fixed_wait = -1;
        fa = $urandom & 32'hFFFF_FFFC;
        da = $urandom & 32'hFFFF_FFFC;
        if_req = 1; if_addr = fa; d_read = 1; d_addr = da;
        wait_for(0, 10, ok);
        total++;
        if (!ok || mem_addr !== da || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL cont_first: got %b %h want 1 %h", ok, mem_addr, da);
        end
        wait_for(2, 10, ok);
        d_read = 0;
        wait_for(0, 10, ok);
        total++;
        if (!ok || mem_addr !== fa || mem_sel !== 4'hF) begin
            bad++;
            $display("FAIL cont_fetch: got %b %h want 1 %h", ok, mem_addr, fa);
        end
        wait_for(1, 10, ok);
        if_req = 0;
        da = $urandom & 32'hFFFF_FFFC;
        d_read = 1; d_addr = da;
        wait_for(2, 12, ok);
        d_read = 0;
        cyc();
        fa = $urandom & 32'hFFFF_FFFC;
        da = $urandom & 32'hFFFF_FFFC;
        if_req = 1; if_addr = fa; d_read = 1; d_addr = da;
        wait_for(0, 10, ok);
        total++;
        if (!ok || mem_addr !== fa) begin
            bad++;
            $display("FAIL cont_fair: got %b %h want 1 %h", ok, mem_addr, fa);
        end
        wait_for(1, 10, ok);
        if_req = 0;
        wait_for(2, 12, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL cont_last_data: got no d_done want d_done");
        end
        d_read = 0;
        cyc();
    endtask

    task automatic test_store();
        bit ok;
        int pulses;
        do_reset();
        mem_m[0] = 32'h0C80_0183;
        fixed_wait = 4;
        d_write = 1; d_read = 0; d_addr = 32'h0000_2000;
        d_wdata = 32'hDEAD_BEEF; d_sel = 4'b0011;
        wait_for(0, 10, ok);
        total++;
        if (!ok || mem_we !== 1'b1 || mem_addr !== 32'h2000 ||
            mem_wdata !== 32'hDEAD_BEEF || mem_sel !== 4'b0011) begin
            bad++;
            $display("FAIL store_grant: got %b %b %h %h %h", ok, mem_we,
                     mem_addr, mem_wdata, mem_sel);
        end
        d_addr = $urandom; d_wdata = $urandom; d_sel = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 ||
                mem_addr !== 32'h2000 || mem_wdata !== 32'hDEAD_BEEF ||
                mem_sel !== 4'b0011) begin
                bad++;
                $display("FAIL store_hold: got %b %b %h %h %h want held",
                         mem_req, mem_we, mem_addr, mem_wdata, mem_sel);
            end
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (d_done === 1'b1) begin
                pulses++;
                d_write = 0;
            end
        end
        total++;
        if (pulses != 1 || d_rdata !== 32'h0) begin
            bad++;
            $display("FAIL store_done: got %0d %h want 1 0", pulses, d_rdata);
        end
        fixed_wait = 0;
        d_read = 1; d_addr = 32'h0000_2000;
        wait_for(2, 10, ok);
        d_read = 0;
        total++;
        if (!ok || d_rdata !== 32'h0C80_BEEF) begin
            bad++;
            $display("FAIL store_readback: got %h want 0c80beef", d_rdata);
        end
        cyc();
    endtask

    task automatic test_stall();
        bit seen;
        do_reset();
        fixed_wait = 5;
        if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (if_done === 1'b1) begin
                seen = 1;
                break;
            end
            total++;
            if (stall_o !== 1'b1) begin
                bad++;
                $display("FAIL stall_wait: got %b want 1", stall_o);
            end
        end
        total++;
        if (!seen || stall_o !== 1'b0) begin
            bad++;
            $display("FAIL stall_done: got %b %b want 1 0", seen, stall_o);
        end
        if_req = 0;
        cyc();
        total++;
        if (stall_o !== 1'b0) begin
            bad++;
            $display("FAIL stall_after: got %b want 0", stall_o);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int pulses;
        do_reset();
        no_ack = 1;
        d_read = 1; d_addr = $urandom & 32'hFFFF_FFFC;
        wait_for(0, 10, ok);
        cyc();
        cyc();
        nrst = 0; force_ack = 1; d_read = 0;
        cyc();
        nrst = 1;
        pulses = 0;
        cyc();
        if (d_done === 1'b1) pulses++;
        force_ack = 0; no_ack = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (d_done === 1'b1) pulses++;
        end
        total++;
        if (!ok || pulses != 0 || d_rdata !== 32'h0 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got %b %0d %h %b want 1 0 0 0",
                     ok, pulses, d_rdata, mem_req);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        no_ack = 1;
        if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
`ifdef T07_ARB_TIMEOUT_EN
        wait_for(3, 30, ok);
        total++;
        if (!ok || instr_o !== NOP || if_done !== 1'b1 ||
            mem_req !== 1'b0) begin
            bad++;
            $display("FAIL timeout: got %b %h %b %b want 1 %h 1 0",
                     ok, instr_o, if_done, mem_req, NOP);
        end
        if_req = 0;
        no_ack = 0;
        cyc();
`else
        repeat (20) cyc();
        total++;
        if (mem_req !== 1'b1 || arb_err !== 1'b0) begin
            bad++;
            $display("FAIL no_timeout: got %b %b want 1 0", mem_req, arb_err);
        end
        no_ack = 0;
        wait_for(1, 10, ok);
        if_req = 0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL no_timeout_done: got no if_done want if_done");
        end
        cyc();
`endif
    endtask

    task automatic new_data_req();
        int k;
        k = int'($urandom_range(0, 2));
        d_read  = (k != 1);
        d_write = (k != 0);
        d_addr  = $urandom & 32'hFFFF_FFFC;
        d_wdata = $urandom;
        d_sel   = 4'($urandom);
    endtask

    task automatic test_random();
        do_reset();
        fixed_wait = -1;
        for (int i = 0; i < 600; i++) begin
            if (if_req && c_fd) begin
                if ($urandom_range(0, 1) == 0) if_req = 0;
                else if_addr = $urandom & 32'hFFFF_FFFC;
            end else if (!if_req && $urandom_range(0, 3) == 0) begin
                if_req = 1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if ((d_read || d_write) && c_dd) begin
                if ($urandom_range(0, 1) == 0) begin
                    d_read = 0;
                    d_write = 0;
                end else begin
                    new_data_req();
                end
            end else if (!(d_read || d_write) &&
                         $urandom_range(0, 3) == 0) begin
                new_data_req();
            end
            cyc();
        end
        if_req = 0; d_read = 0; d_write = 0;
        repeat (8) cyc();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
        nrst = 0; if_req = 0; if_addr = 0;
        d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0; d_sel = 0;
        mem_ack = 0; mem_rdata = 0;
        c_busy = 0; n_busy = 0; c_win = 0; n_win = 0; c_we = 0; n_we = 0;
        c_fd = 0; n_fd = 0; c_dd = 0; n_dd = 0; c_err = 0; n_err = 0;
        c_addr = 0; n_addr = 0; c_wdata = 0; n_wdata = 0;
        c_sel = 0; n_sel = 0; c_instr = 0; n_instr = 0;
        c_rdata = 0; n_rdata = 0;
        m_last = 0; wait_left = 0; cnt = 0;
        test_reset();
        test_contention();
        test_store();
        test_stall();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
